// File: rtl/lut_multiplier_seq.sv
// Sequential LUT multiplier: consumes DIGIT bits of B per cycle against a table of multiples of |A|.
// Latency N+2 cycles from acceptance to out_valid; a stalled out_ready holds DONE and blocks new operands.
module lut_multiplier_seq #(
    parameter int WA     = 32,
    parameter int WB     = 8,
    parameter int DIGIT  = 2,
    parameter int SIGNED = 0
) (
    input  logic               clk_mb,
    input  logic               rst_mb,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WA-1:0]      source_number_mb_0,
    input  logic [WB-1:0]      source_number_mb_1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WA+WB-1:0]   result_mb
);

    localparam int N  = WB / DIGIT;
    localparam int W  = WA + WB;
    localparam int LW = WA + DIGIT;
    localparam int NL = 1 << DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [WA-1:0] r_a;
    logic [WB-1:0] r_b;
    logic          r_neg;
    logic [LW-1:0] r_lut [NL];
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WA-1:0]    w_a_mag;
    logic [WB-1:0]    w_b_mag;
    logic [DIGIT-1:0] w_digit;
    logic [W-1:0]     w_term;
    logic [W-1:0]     w_acc_next;
    logic [W-1:0]     w_res;
    logic             w_last;

    // Magnitudes are taken as unsigned, so -2^(WA-1) maps cleanly to 2^(WA-1).
    assign w_a_neg    = (SIGNED != 0) && source_number_mb_0[WA-1];
    assign w_b_neg    = (SIGNED != 0) && source_number_mb_1[WB-1];
    assign w_a_mag    = w_a_neg ? -source_number_mb_0 : source_number_mb_0;
    assign w_b_mag    = w_b_neg ? -source_number_mb_1 : source_number_mb_1;

    // r_b is shifted down each RUN cycle, so the current digit is always at the bottom.
    assign w_digit    = r_b[DIGIT-1:0];
    assign w_term     = W'(r_lut[w_digit]) << (32'(r_cnt) * DIGIT);
    assign w_acc_next = r_acc + w_term;
    assign w_res      = r_neg ? -w_acc_next : w_acc_next;
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk_mb) begin
        if (rst_mb) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < NL; k++) begin
                r_lut[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int k = 0; k < NL; k++) begin
                        r_lut[k] <= LW'(r_a) * LW'(k);
                    end
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_b   <= r_b >> DIGIT;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_result    <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result_mb = r_result;

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Drives seven configurations of lut_multiplier_seq in lockstep and scores each against a direct product.
module tb_lut_multiplier_seq;

    localparam int NDUT = 7;

    function automatic int dig_of(input int g);
        case (g)
            2, 4:    return 1;
            3, 6:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int wb_of(input int g);
        return (g >= 4) ? 16 : 8;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [15:0] b;
    logic        ir  [NDUT];
    logic        ov  [NDUT];
    logic [47:0] res [NDUT];

    logic [47:0] exp_q [$];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D  = dig_of(g);
        localparam int BW = wb_of(g);
        localparam int S  = (g == 1) ? 1 : 0;
        logic [32+BW-1:0] w_res;
        lut_multiplier_seq #(.WA(32), .WB(BW), .DIGIT(D), .SIGNED(S)) u_dut (
            .clk_mb             (clk),
            .rst_mb             (rst),
            .in_valid           (in_valid),
            .in_ready           (ir[g]),
            .source_number_mb_0 (a),
            .source_number_mb_1 (b[BW-1:0]),
            .out_valid          (ov[g]),
            .out_ready          (out_ready),
            .result_mb          (w_res)
        );
        assign res[g] = 48'(w_res);
    end

    function automatic logic [47:0] model(input int g, input logic [31:0] av, input logic [15:0] bv);
        longint unsigned p;
        longint          sa;
        longint          sb;
        int              wb;
        logic [7:0]      b8;
        wb = wb_of(g);
        b8 = bv[7:0];
        if (g == 1) begin
            sa = longint'($signed(av));
            sb = longint'($signed(b8));
            p  = longint'(sa * sb);
        end else begin
            p = 64'(av) * (64'(bv) & ((64'd1 << wb) - 64'd1));
        end
        return 48'(p & ((64'd1 << (32 + wb)) - 64'd1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic do_op(input logic [31:0] av, input logic [15:0] bv);
        int          seen [NDUT];
        logic [47:0] got  [NDUT];
        int          cyc;
        int          done_n;
        for (int g = 0; g < NDUT; g++) begin
            exp_q.push_back(model(g, av, bv));
            seen[g] = 0;
            got[g]  = '0;
        end
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_cycle1", 64'(ir[0]), 64'd0);
        cyc = 1; done_n = 0;
        while (done_n < NDUT && cyc <= 40) begin
            for (int g = 0; g < NDUT; g++) begin
                if (ov[g] && seen[g] == 0) begin
                    seen[g] = cyc;
                    got[g]  = res[g];
                    done_n++;
                end
            end
            if (done_n < NDUT) begin
                @(negedge clk);
                cyc++;
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("latency_g%0d_%0h_%0h", g, av, bv), 64'(seen[g]),
                64'(wb_of(g) / dig_of(g) + 2));
            chk($sformatf("result_g%0d_%0h_%0h", g, av, bv), 64'(got[g]), 64'(exp_q.pop_front()));
        end
        @(negedge clk);
        chk("out_valid_after_accept", 64'(ov[0]), 64'd0);
        chk("in_ready_after_accept", 64'(ir[0]), 64'd1);
    endtask

    initial begin
        logic [47:0] bp_exp;
        logic [47:0] bp_got;
        int          cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(ov[0]), 64'd0);
        chk("reset_in_ready", 64'(ir[0]), 64'd1);
        chk("reset_result", 64'(res[0]), 64'd0);

        do_op(32'd5, 16'd7);
        do_op(32'hFFFF_FFFF, 16'hFFFF);
        do_op(32'hFFFF_FFFD, 16'h0005);
        do_op(32'h8000_0000, 16'h0080);
        do_op(32'd0, 16'd0);
        do_op(32'hDEAD_BEEF, 16'd0);

        // Backpressure: hold out_ready low for 10 cycles while offering new operands.
        exp_q.push_back(model(0, 32'h1234_5678, 16'h009A));
        @(negedge clk);
        a = 32'h1234_5678; b = 16'h009A; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!ov[0] && cyc <= 40) begin
            @(negedge clk);
            cyc++;
        end
        bp_exp = exp_q.pop_front();
        bp_got = res[0];
        chk("bp_latency", 64'(cyc), 64'd6);
        chk("bp_result", 64'(bp_got), 64'(bp_exp));
        for (int i = 0; i < 10; i++) begin
            a = 32'hCAFE_0000 + 32'(i); b = 16'h0011; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), 64'(ov[0]), 64'd1);
            chk($sformatf("bp_hold_result_%0d", i), 64'(res[0]), 64'(bp_exp));
            chk($sformatf("bp_hold_in_ready_%0d", i), 64'(ir[0]), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(ov[0]), 64'd0);
        chk("bp_release_in_ready", 64'(ir[0]), 64'd1);
        chk("bp_result_kept", 64'(res[0]), 64'(bp_exp));
        repeat (25) @(negedge clk);

        // Reset during the second RUN cycle discards the operation.
        a = 32'd7; b = 16'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_reset_valid", 64'(ov[0]), 64'd0);
        chk("midrun_reset_in_ready", 64'(ir[0]), 64'd1);
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("midrun_reset_result_g%0d", g), 64'(res[g]), 64'd0);
        end
        do_op(32'd3, 16'd3);

        for (int i = 0; i < 4; i++) begin
            do_op($urandom, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lut_multiplier_seq.md
# lut_multiplier_seq

Parametrised sequential LUT multiplier: the next generation of the fixed 32x2-bit LUT multiplier. It multiplies a WA-bit operand by a WB-bit operand. Each cycle it consumes one DIGIT-bit slice of the multiplier through a 2^DIGIT-entry multiple table (0, A, 2A, …). It adds valid/ready handshaking on both sides, a selectable signed mode and backpressure on the result. It sits between the operand source and the result consumer in the multiplier datapath, replacing the fixed-width conditional multiplier where wider multipliers are needed.

## Interface
- WA, default 32: width of multiplicand A.
- WB, default 8: width of multiplier B. WB % DIGIT must be 0.
- DIGIT, default 2: bits of B consumed per RUN cycle. Legal values 1..4. The LUT has 2^DIGIT entries.
- SIGNED, default 0: 0 = unsigned operands; 1 = two's-complement operands and result.
- clk_mb, input, 1: clock. All state updates on the rising edge.
- rst_mb, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands. High only in IDLE.
- source_number_mb_0, input, WA: multiplicand A.
- source_number_mb_1, input, WB: multiplier B.
- out_valid, output, 1: result valid. Held until accepted.
- out_ready, input, 1: consumer accepts the result.
- result_mb, output, WA+WB: product A*B.

## Operation
- **Derived values:** N = WB/DIGIT digits; W = WA+WB.
- **FSM states:** IDLE, LOAD, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - When in_valid=1, register A and B and go to LOAD.
  - If SIGNED=1, register |A| and |B| as unsigned WA- and WB-bit magnitudes, and register neg = sign(A) XOR sign(B).
  - |−2^(WA−1)| = 2^(WA−1) as unsigned. No overflow.
- **LOAD (1 cycle):**
  - Fill lut[k] = k*|A| for k = 0..2^DIGIT−1. Each entry is WA+DIGIT bits.
  - Clear the accumulator and the digit counter.
- **RUN (N cycles):**
  - Cycle i (i = 0..N−1): acc += lut[B[i*DIGIT +: DIGIT]] << (i*DIGIT). Least-significant digit first.
  - The accumulator is W bits; unsigned products never exceed W bits.
  - The counter wraps to DONE after i = N−1.
- **DONE:**
  - Registered output result_mb = neg ? −acc : acc, computed mod 2^W. neg is forced to 0 when SIGNED=0.
  - out_valid=1 is held until out_ready=1. In that cycle, go to IDLE.
  - result_mb holds its value after acceptance until the next DONE.
- **Backpressure:** a stalled out_ready keeps DONE indefinitely. in_ready stays 0, so no new operands are accepted.
- **Reset:**
  - rst_mb=1 in any state: next state IDLE.
  - out_valid=0, in_ready=1 from the cycle after reset.
  - result_mb=0, acc=0, counter=0, LUT cleared.
  - A reset mid-RUN or mid-DONE discards the operation. No partial result appears.
- **Simultaneous events:** rst_mb has priority over in_valid and out_ready.
- **Zero operands:** take the full latency. The result is 0, with no early-out.

## Timing
- **Operand acceptance:** on edge E0, where in_valid & in_ready is sampled high.
  - LOAD is the cycle after E0.
  - RUN spans cycles 2..N+1.
  - out_valid is high from cycle N+2.
  - Defaults (N=4): out_valid at cycle 6 after acceptance.
- **Throughput:** at most one product every N+3 cycles. This assumes out_ready=1 on the first DONE cycle, plus one IDLE cycle.
- **in_ready:** registered-state decode, combinational from state only. No dependence on in_valid.
- **Outputs:** out_valid and result_mb come straight from registers.

## Test plan
- **Unsigned basic** (defaults, SIGNED=0): A=5, B=7 → result_mb=0x0000000023. out_valid at cycle 6 after acceptance; in_ready=0 from cycle 1 until return to IDLE.
- **Unsigned max:** A=0xFFFFFFFF, B=0xFF → result_mb=0xFEFFFFFF01.
- **Signed mode** (SIGNED=1):
  - A=0xFFFFFFFD (−3), B=0x05 → 0xFFFFFFFFF1 (−15).
  - A=0x80000000, B=0x80 → 0x4000000000.
- **Backpressure:** out_ready held 0 for 10 cycles after out_valid. result_mb and out_valid stay stable and in_valid is ignored. After the out_ready pulse, out_valid=0 and in_ready=1 next cycle.
- **Reset mid-RUN:** rst_mb=1 at RUN cycle 2 → next cycle state IDLE, out_valid=0, result_mb=0. A new A=3, B=3 then yields 9 with normal latency.
- **Parameter sweep:** DIGIT ∈ {1,2,4}, WB ∈ {8,16}, random operands against a reference product. Check latency = N+2.
